// File: rtl/ysyx_22041461_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-size encoding, response cause codes, FSM state encoding and
// the alignment predicate used at request acceptance.
package ysyx_22041461_lsu_pkg;

    // Access size (bytes = 2^size)
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // Response cause codes
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_BUS      = 2'b11;

    // FSM state encoding
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t S_IDLE     = 2'd0;
    localparam lsu_state_t S_BUS_REQ  = 2'd1;
    localparam lsu_state_t S_BUS_WAIT = 2'd2;
    localparam lsu_state_t S_RESP     = 2'd3;

    // True when addr is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic mis;
        unique case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_22041461_lsu_if.sv
// Bus bundle for the load/store unit: core request/response channel and the
// memory request/response channel.
//   slave  : the LSU view (accepts core requests, issues memory requests)
//   master : the environment view (core plus memory model)
interface ysyx_22041461_lsu_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    // core request
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    // core response
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [1:0]        resp_cause;
    // memory request
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    // memory response
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err, resp_cause,
        input  resp_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err, resp_cause,
        output resp_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

endinterface

// File: rtl/ysyx_22041461_lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
// Ports:
//   size      access size (2^size bytes)
//   zext      1 = zero-extend loads, 0 = sign-extend
//   off       byte offset of the access within the bus word
//   wdata     LSB-justified store data
//   rdata     raw bus read data
//   wdata_sh  store data moved onto its byte lanes
//   wmask     byte enables for the store
//   rdata_ext load data shifted down, truncated and extended
module ysyx_22041461_lsu_align
    import ysyx_22041461_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned OFF_W  = $clog2(STRB_W)
) (
    input  logic [1:0]        size,
    input  logic              zext,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [STRB_W-1:0] wmask,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [OFF_W+2:0]  shamt;
    logic [DATA_W-1:0] rd_sh;
    logic [STRB_W-1:0] base_mask;

    assign shamt = {off, 3'b000};

    always_comb begin
        wdata_sh  = wdata << shamt;
        rd_sh     = rdata >> shamt;
        base_mask = '0;
        rdata_ext = '0;
        unique case (size)
            SIZE_B: begin
                base_mask = STRB_W'(1);
                rdata_ext = zext ? DATA_W'(rd_sh[7:0]) : DATA_W'($signed(rd_sh[7:0]));
            end
            SIZE_H: begin
                base_mask = STRB_W'(2'b11);
                rdata_ext = zext ? DATA_W'(rd_sh[15:0]) : DATA_W'($signed(rd_sh[15:0]));
            end
            SIZE_W: begin
                base_mask = STRB_W'(4'hf);
                rdata_ext = zext ? DATA_W'(rd_sh[31:0]) : DATA_W'($signed(rd_sh[31:0]));
            end
            default: begin
                // Full-width access: no extension, zext is irrelevant.
                base_mask = '1;
                rdata_ext = rd_sh;
            end
        endcase
        wmask = base_mask << off;
    end

endmodule

// File: rtl/ysyx_22041461_lsu.sv
// Load/store unit: takes one core request at a time, checks alignment, issues a
// single aligned memory transaction, and returns a (possibly error) response.
// Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous active-high reset
//   bus  core request/response + memory request/response channels (slave view)
// Parameters: ADDR_W address width, DATA_W bus width (32/64), TIMEOUT maximum
// cycles spent waiting for a memory response before aborting.
module ysyx_22041461_lsu
    import ysyx_22041461_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22041461_lsu_if.slave  bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    lsu_state_t        state_q, state_d;
    logic              armed_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Latched request
    logic              we_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Registered response
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        cause_q, cause_d;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] store_data;
    logic [STRB_W-1:0] store_mask;
    logic [DATA_W-1:0] load_data;

    // armed_q holds req_ready low until the first edge after reset release.
    assign bus.req_ready = (state_q == S_IDLE) && armed_q;
    assign accept        = bus.req_valid && bus.req_ready;
    assign illegal       = (bus.req_size == SIZE_D) && (DATA_W == 32);
    assign misaligned    = is_misaligned(bus.req_addr[2:0], bus.req_size);
    assign off           = addr_q[OFF_W-1:0];

    ysyx_22041461_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size      (size_q),
        .zext      (zext_q),
        .off       (off),
        .wdata     (wdata_q),
        .rdata     (bus.mem_resp_rdata),
        .wdata_sh  (store_data),
        .wmask     (store_mask),
        .rdata_ext (load_data)
    );

    assign bus.mem_req_valid = (state_q == S_BUS_REQ);
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign bus.mem_wdata     = store_data;
    assign bus.mem_wmask     = we_q ? store_mask : '0;

    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_cause = cause_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (illegal || misaligned) begin
                        // Rejected requests skip the bus entirely.
                        state_d = S_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        cause_d = illegal ? CAUSE_BUS : CAUSE_MISALIGN;
                    end else begin
                        state_d = S_BUS_REQ;
                    end
                end
            end
            S_BUS_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_BUS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_BUS_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = S_RESP;
                    if (bus.mem_resp_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        cause_d = CAUSE_BUS;
                    end else begin
                        rdata_d = we_q ? '0 : load_data;
                        err_d   = 1'b0;
                        cause_d = CAUSE_NONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th wait cycle with no response.
                    state_d = S_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= SIZE_B;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            zext_q  <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
// Directed self-checking bench for ysyx_22041461_lsu (TIMEOUT = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ysyx_22041461_lsu;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ysyx_22041461_lsu_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ysyx_22041461_lsu #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a request for one cycle, then scramble the request fields.
    // Returns in the cycle after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic zext,
                         input logic [63:0] addr, input logic [63:0] wdata);
        check_eq("issue_req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = zext;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        tick();
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_size     = ~size;
        bus.req_unsigned = ~zext;
        bus.req_addr     = ~addr;
        bus.req_wdata    = ~wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_we         = 1'b0;
        bus.req_size       = 2'b00;
        bus.req_unsigned   = 1'b0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.resp_ready     = 1'b1;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        bus.mem_resp_err   = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        // Load W signed, zero waits
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 64'h8765_4321_0000_0000;
        issue(1'b0, 2'b10, 1'b0, 64'h8000_0004, 64'h0);
        check_eq("lw_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        check_eq("lw_mem_addr", bus.mem_addr, 64'h8000_0000);
        check_eq("lw_mem_we", 64'(bus.mem_we), 64'd0);
        check_eq("lw_mem_wmask", 64'(bus.mem_wmask), 64'd0);
        tick();
        check_eq("lw_c2_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("lw_c2_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        tick();
        check_eq("lw_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("lw_resp_rdata", bus.resp_rdata, 64'hFFFF_FFFF_8765_4321);
        check_eq("lw_resp_err", 64'(bus.resp_err), 64'd0);
        check_eq("lw_req_ready_in_resp", 64'(bus.req_ready), 64'd0);
        tick();
        check_eq("lw_done_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("lw_done_req_ready", 64'(bus.req_ready), 64'd1);

        // Bus error on a load B
        bus.mem_resp_err = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 64'h8000_0005, 64'h0);
        tick();
        tick();
        check_eq("berr_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("berr_resp_err", 64'(bus.resp_err), 64'd1);
        check_eq("berr_resp_cause", 64'(bus.resp_cause), 64'd3);
        check_eq("berr_resp_rdata", bus.resp_rdata, 64'd0);
        bus.mem_resp_err   = 1'b0;
        bus.mem_resp_valid = 1'b0;
        tick();

        // Store H at offset 6
        issue(1'b1, 2'b01, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD);
        check_eq("sh_mem_wmask", 64'(bus.mem_wmask), 64'hC0);
        check_eq("sh_mem_wdata", bus.mem_wdata, 64'hABCD_0000_0000_0000);
        check_eq("sh_mem_we", 64'(bus.mem_we), 64'd1);
        check_eq("sh_mem_addr", bus.mem_addr, 64'h8000_0000);
        bus.mem_resp_valid = 1'b1;
        tick();
        tick();
        check_eq("sh_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("sh_resp_err", 64'(bus.resp_err), 64'd0);
        check_eq("sh_resp_rdata", bus.resp_rdata, 64'd0);
        bus.mem_resp_valid = 1'b0;
        tick();

        // Timeout with TIMEOUT=4
        issue(1'b0, 2'b11, 1'b0, 64'h8000_0008, 64'h0);
        check_eq("to_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        tick();
        for (int k = 2; k <= 5; k++) begin
            check_eq("to_wait_resp_valid", 64'(bus.resp_valid), 64'd0);
            tick();
        end
        check_eq("to_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("to_resp_err", 64'(bus.resp_err), 64'd1);
        check_eq("to_resp_cause", 64'(bus.resp_cause), 64'd2);
        tick();
        // Late memory response must be ignored
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 64'h0000_0000_0000_DEAD;
        check_eq("to_late_req_ready", 64'(bus.req_ready), 64'd1);
        tick();
        check_eq("to_late_resp_valid_a", 64'(bus.resp_valid), 64'd0);
        tick();
        check_eq("to_late_resp_valid_b", 64'(bus.resp_valid), 64'd0);

        // Following load B signed completes; response held while resp_ready low
        bus.mem_resp_rdata = 64'h0000_0000_0000_8000;
        bus.resp_ready     = 1'b0;
        issue(1'b0, 2'b00, 1'b0, 64'h8000_0001, 64'h0);
        tick();
        tick();
        check_eq("lb_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("lb_resp_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("lb_resp_cause", 64'(bus.resp_cause), 64'd0);
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 64'h0;
        tick();
        check_eq("lb_hold_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("lb_hold_resp_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        bus.resp_ready = 1'b1;
        tick();
        check_eq("lb_done_resp_valid", 64'(bus.resp_valid), 64'd0);

        // Store W with mem_req_ready low 5 cycles and resp_ready low 3 cycles
        bus.mem_req_ready = 1'b0;
        bus.resp_ready    = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 64'h8000_000C, 64'h0000_0000_1122_3344);
        for (int k = 1; k <= 5; k++) begin
            check_eq("sw_hold_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
            check_eq("sw_hold_mem_addr", bus.mem_addr, 64'h8000_0008);
            check_eq("sw_hold_mem_wdata", bus.mem_wdata, 64'h1122_3344_0000_0000);
            check_eq("sw_hold_mem_wmask", 64'(bus.mem_wmask), 64'hF0);
            tick();
        end
        check_eq("sw_c6_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        check_eq("sw_wait_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("sw_hold_resp_valid", 64'(bus.resp_valid), 64'd1);
            check_eq("sw_hold_resp_err", 64'(bus.resp_err), 64'd0);
            check_eq("sw_hold_resp_cause", 64'(bus.resp_cause), 64'd0);
            check_eq("sw_hold_resp_rdata", bus.resp_rdata, 64'd0);
            tick();
        end
        check_eq("sw_c11_resp_valid", 64'(bus.resp_valid), 64'd1);
        bus.resp_ready    = 1'b1;
        bus.mem_req_ready = 1'b1;
        tick();
        check_eq("sw_done_resp_valid", 64'(bus.resp_valid), 64'd0);

        // Misaligned load H unsigned
        issue(1'b0, 2'b01, 1'b1, 64'h8000_0003, 64'h0);
        check_eq("mis_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("mis_resp_err", 64'(bus.resp_err), 64'd1);
        check_eq("mis_resp_cause", 64'(bus.resp_cause), 64'd1);
        check_eq("mis_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        tick();
        check_eq("mis_after_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);

        // Reset pulsed while in BUS_WAIT
        issue(1'b1, 2'b01, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD);
        tick();
        check_eq("rw_pre_mem_wmask", 64'(bus.mem_wmask), 64'hC0);
        rst = 1'b1;
        #1;
        check_eq("rw_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rw_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check_eq("rw_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rw_resp_err", 64'(bus.resp_err), 64'd0);
        check_eq("rw_resp_cause", 64'(bus.resp_cause), 64'd0);
        check_eq("rw_resp_rdata", bus.resp_rdata, 64'd0);
        check_eq("rw_mem_wmask", 64'(bus.mem_wmask), 64'd0);
        tick();
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        tick();
        check_eq("rw_rel_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rw_rel_resp_valid", 64'(bus.resp_valid), 64'd0);
        tick();
        check_eq("rw_rel2_resp_valid", 64'(bus.resp_valid), 64'd0);

        // Load D after reset: extension flag has no effect
        bus.mem_resp_rdata = 64'h8000_0000_0000_0001;
        issue(1'b0, 2'b11, 1'b0, 64'h8000_0018, 64'h0);
        check_eq("ld_mem_addr", bus.mem_addr, 64'h8000_0018);
        tick();
        tick();
        check_eq("ld_resp_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("ld_resp_rdata", bus.resp_rdata, 64'h8000_0000_0000_0001);
        bus.mem_resp_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_lsu.md
YSYX_22041461_LSU -- requirements
Module: ysyx_22041461_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning bus/data width; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum BUS_WAIT cycles before abort; minimum 1.
REQ-004 SHALL have port: clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have core request ports:
- req_valid  in  1
- req_ready  out  1
- req_we  in  1  (1 = store)
- req_size  in  2  (00 B, 01 H, 10 W, 11 D)
- req_unsigned  in  1  (load zero-extend)
- req_addr  in  ADDR_W
- req_wdata  in  DATA_W  (store data, LSB-justified)
REQ-007 SHALL have core response ports:
- resp_valid  out  1
- resp_ready  in  1
- resp_rdata  out  DATA_W
- resp_err  out  1
- resp_cause  out  2  (00 none, 01 misaligned, 10 timeout, 11 illegal size/bus error)
REQ-008 SHALL have memory request ports:
- mem_req_valid  out  1
- mem_req_ready  in  1
- mem_we  out  1
- mem_addr  out  ADDR_W  (aligned to DATA_W/8)
- mem_wdata  out  DATA_W
- mem_wmask  out  DATA_W/8
REQ-009 SHALL have memory response ports:
- mem_resp_valid  in  1
- mem_resp_rdata  in  DATA_W
- mem_resp_err  in  1

Function
REQ-010 SHALL implement FSM IDLE -> BUS_REQ -> BUS_WAIT -> RESP -> IDLE; req_ready=1 only in IDLE with rst low.
REQ-011 SHALL latch all req_* fields on the req_valid&&req_ready cycle; later changes on req_* have no effect.
REQ-012 SHALL check alignment at acceptance:
- Condition: addr mod 2^size != 0 -> misaligned.
- Condition: size=11 with DATA_W=32 -> illegal.
- Action: go IDLE->RESP with resp_err=1 and matching cause.
- Action: no mem_req_valid is issued; resp_valid rises the cycle after acceptance.
REQ-013 SHALL, for legal requests, assert mem_req_valid from the cycle after acceptance and hold it with stable payload until mem_req_ready; handshake cycle -> BUS_WAIT.
REQ-014 SHALL drive mem_addr = addr with low log2(DATA_W/8) bits cleared, and off = those bits.
REQ-015 SHALL drive stores as:
- mem_wdata = wdata << (8*off).
- mem_wmask = ((1<<2^size)-1) << off.
- Loads drive mem_wmask=0.
REQ-016 SHALL, in BUS_WAIT, count cycles; on mem_resp_valid go RESP the next cycle.
- Loads: resp_rdata = (mem_resp_rdata >> 8*off) truncated to 2^size bytes, then sign-extended (req_unsigned=0) or zero-extended (1); size D ignores req_unsigned.
- Stores: resp_rdata=0.
- mem_resp_err=1 -> resp_err=1, cause 11, resp_rdata=0.
REQ-017 SHALL, if TIMEOUT cycles elapse in BUS_WAIT without mem_resp_valid, enter RESP with cause 10; mem_resp_valid arriving outside BUS_WAIT is ignored.
REQ-018 SHALL hold resp_valid and the response fields stable in RESP until resp_ready; the handshake cycle returns to IDLE; req_ready rises the following cycle (no same-cycle reacceptance).
REQ-019 SHALL give minimum load latency of 3 cycles from acceptance to resp_valid when mem_req_ready and mem_resp_valid arrive with zero wait.
REQ-020 SHALL keep mem_req_valid=0 outside BUS_REQ and resp_valid=0 outside RESP.

Reset
REQ-021 SHALL, on rst assertion, immediately force state IDLE, timeout counter 0, and outputs to 0: req_ready, mem_req_valid, resp_valid, resp_err, resp_cause, resp_rdata, mem_wmask.
REQ-022 SHALL abandon any in-flight transaction on reset mid-operation, with no response; a late mem_resp_valid is ignored per REQ-017.
REQ-023 SHALL assert req_ready in the first clock edge after rst deasserts.

Structure
REQ-024 SHALL place the size encoding, cause codes and FSM state enum in package ysyx_22041461_lsu_pkg.
REQ-025 SHALL implement shift/mask/extend in combinational sub-module ysyx_22041461_lsu_align, shared by the store and load paths.

Verification
REQ-026 SHALL cover: load W signed, addr 0x8000_0004, mem_rdata 0x8765_4321_0000_0000, zero waits -> mem_addr 0x8000_0000; resp_rdata 0xFFFF_FFFF_8765_4321 at acceptance+3.
REQ-027 SHALL cover: store H, addr 0x8000_0006, wdata 0xABCD -> mem_wmask 0xC0, mem_wdata 0xABCD_0000_0000_0000, resp_err 0.
REQ-028 SHALL cover: load H unsigned, addr 0x8000_0003 -> no mem_req_valid; resp_err 1, cause 01 one cycle after acceptance.
REQ-029 SHALL cover: TIMEOUT=4, mem never responds -> resp cause 10 after 4 BUS_WAIT cycles; a later mem_resp_valid is ignored and the next request completes normally.
REQ-030 SHALL cover: mem_req_ready low 5 cycles and resp_ready low 3 cycles -> payload and response held stable throughout.
REQ-031 SHALL cover: rst pulsed while in BUS_WAIT -> all outputs 0 asynchronously, req_ready=1 one edge after release, no resp_valid.
